// File: rtl/seg_shift_tx.sv
// Serial transmitter for shift-register display chains: captures a parallel frame on a
// start rising edge and shifts it out on SEGDT under a registered, divided SEGCLK.
module seg_shift_tx #(
  parameter int DATA_W     = 64,
  parameter int CLK_DIV    = 1,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] PData,
  output logic              busy,
  output logic              done,
  output logic              SEGCLK,
  output logic              SEGCLR,
  output logic              SEGDT,
  output logic              SEGEN,
  output logic [1:0]        dbg_state_o
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(DATA_W);
  localparam logic [PW-1:0] PH_RISE  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_DONE = GW'((GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

  // Handshake: a request is the cycle in which start is seen newly high; each
  // request is captured into a one-deep shadow (latest wins) until a load consumes it.
  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        samp_q;
  logic [DATA_W-1:0] shadow_q, sh_q, sh_d, load_src;
  logic              pend_q, req, load;
  logic [BW-1:0]     bit_q, bit_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              segclk_q, segclk_d, segdt_q, segdt_d;
  logic              segclr_q, segen_q;

  assign req = (samp_q == 2'b01);
  // A request landing on the load edge itself is taken directly, so it is never stale.
  assign load_src = req ? PData : shadow_q;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    segclk_d = segclk_q;
    segdt_d  = segdt_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        segclk_d = 1'b0;
        segdt_d  = 1'b0;
        load     = pend_q;
      end
      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d  = '0;
          segclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            bit_d   = BIT_END;
            state_d = GAP;
            segdt_d = 1'b0;
            gap_d   = '0;
            done_d  = (GAP_CYCLES == 1);
          end else begin
            bit_d   = bit_q + 1'b1;
            sh_d    = shift_once(sh_q);
            segdt_d = out_bit(shift_once(sh_q));
          end
        end else begin
          phase_d  = phase_q + 1'b1;
          segclk_d = (phase_q >= PH_RISE);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (pend_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d  = gap_q + 1'b1;
          done_d = (gap_q == GAP_DONE);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d  = SHIFT;
      sh_d     = load_src;
      segdt_d  = out_bit(load_src);
      segclk_d = 1'b0;
      phase_d  = '0;
      bit_d    = '0;
      gap_d    = '0;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      samp_q   <= 2'b00;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      sh_q     <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      segclk_q <= 1'b0;
      segdt_q  <= 1'b0;
      segclr_q <= 1'b0;
      segen_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= {samp_q[0], start};
      if (req) shadow_q <= PData;
      if (load)     pend_q <= 1'b0;
      else if (req) pend_q <= 1'b1;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      segclk_q <= segclk_d;
      segdt_q  <= segdt_d;
      segclr_q <= 1'b1;
      segen_q  <= 1'b1;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign SEGCLK      = segclk_q;
  assign SEGDT       = segdt_q;
  assign SEGCLR      = segclr_q;
  assign SEGEN       = segen_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_shift_tx.sv
// Directed bench for seg_shift_tx: unit A is 8-bit MSB-first with CLK_DIV=1,
// unit B is 8-bit LSB-first with CLK_DIV=3; both use a two-cycle gap.
module tb_seg_shift_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] pdata_a = '0, pdata_b = '0;
  logic       a_busy, a_done, a_clk, a_clr, a_dt, a_en;
  logic       b_busy, b_done, b_clk, b_clr, b_dt, b_en;
  logic [1:0] a_st, b_st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_shift_tx #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1), .GAP_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .PData(pdata_a),
    .busy(a_busy), .done(a_done), .SEGCLK(a_clk), .SEGCLR(a_clr),
    .SEGDT(a_dt), .SEGEN(a_en), .dbg_state_o(a_st)
  );

  seg_shift_tx #(.DATA_W(8), .CLK_DIV(3), .MSB_FIRST(0), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .PData(pdata_b),
    .busy(b_busy), .done(b_done), .SEGCLK(b_clk), .SEGCLR(b_clr),
    .SEGDT(b_dt), .SEGEN(b_en), .dbg_state_o(b_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [7:0] d);
    if (sel == 0) begin
      start_a = s;
      pdata_a = d;
    end else begin
      start_b = s;
      pdata_b = d;
    end
  endtask

  // Raises start with d1 right after an edge (t=0 is the next sampled edge) and
  // records bits at SEGCLK rises, load/done timing and busy/high-phase counts.
  task automatic watch(input int sel, input logic [7:0] d1, input int drop_t,
                       input int tr2, input logic [7:0] d2,
                       input int tr3, input logic [7:0] d3, input int budget,
                       output logic [31:0] bits, output int rises, output int load_t,
                       output int done_t1, output int done_tl, output int busy_n,
                       output int done_n, output int hi_n, output int dt_bad);
    logic pc, pd, c, d, b, dn;
    bits = '0; rises = 0; load_t = -1; done_t1 = -1; done_tl = -1;
    busy_n = 0; done_n = 0; hi_n = 0; dt_bad = 0;
    pc = 1'b0; pd = 1'b0;
    drive(sel, 1'b1, d1);
    for (int t = 0; t < budget; t++) begin
      tick();
      c  = (sel == 0) ? a_clk  : b_clk;
      d  = (sel == 0) ? a_dt   : b_dt;
      b  = (sel == 0) ? a_busy : b_busy;
      dn = (sel == 0) ? a_done : b_done;
      if (b && load_t < 0) load_t = t;
      if (b) busy_n++;
      if (c) hi_n++;
      if (dn) begin
        done_n++;
        if (done_t1 < 0) done_t1 = t;
        done_tl = t;
      end
      if (c && !pc) begin
        bits = {bits[30:0], d};
        rises++;
      end
      if (c && pc && (d != pd)) dt_bad++;
      pc = c;
      pd = d;
      if (t == drop_t) drive(sel, 1'b0, 8'h00);
      if (tr2 >= 0 && t == tr2) drive(sel, 1'b1, d2);
      if (tr2 >= 0 && t == tr2 + 2) drive(sel, 1'b0, 8'h00);
      if (tr3 >= 0 && t == tr3) drive(sel, 1'b1, d3);
      if (tr3 >= 0 && t == tr3 + 2) drive(sel, 1'b0, 8'h00);
    end
    drive(sel, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] bits;
    int rises, load_t, done_t1, done_tl, busy_n, done_n, hi_n, dt_bad;

    // Reset values
    repeat (3) tick();
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_segclk", a_clk, 0);
    check("rst_segdt", a_dt, 0);
    check("rst_segclr", a_clr, 0);
    check("rst_segen", a_en, 0);
    check("rst_state", a_st, 0);
    check("rst_b_state", b_st, 0);
    rst = 1'b0;
    tick();
    check("rel_segclr", a_clr, 1);
    check("rel_segen", a_en, 1);
    repeat (3) tick();

    // MSB-first 0xA5, CLK_DIV=1
    watch(0, 8'hA5, 2, -1, 8'h00, -1, 8'h00, 30,
          bits, rises, load_t, done_t1, done_tl, busy_n, done_n, hi_n, dt_bad);
    check("a5_bits", bits[7:0], 8'hA5);
    check("a5_rises", rises, 8);
    check("a5_latency", load_t, 2);
    check("a5_done_ofs", done_t1 - load_t, 17);
    check("a5_done_n", done_n, 1);
    check("a5_busy_n", busy_n, 18);
    check("a5_hi_n", hi_n, 8);
    repeat (4) tick();

    // LSB-first on unit B (CLK_DIV=3)
    watch(1, 8'hA5, 2, -1, 8'h00, -1, 8'h00, 60,
          bits, rises, load_t, done_t1, done_tl, busy_n, done_n, hi_n, dt_bad);
    check("lsb_a5_bits", bits[7:0], 8'hA5);
    check("lsb_a5_rises", rises, 8);
    repeat (4) tick();
    watch(1, 8'h01, 2, -1, 8'h00, -1, 8'h00, 60,
          bits, rises, load_t, done_t1, done_tl, busy_n, done_n, hi_n, dt_bad);
    check("lsb_01_bits", bits[7:0], 8'h80);
    repeat (4) tick();
    watch(1, 8'hF0, 2, -1, 8'h00, -1, 8'h00, 60,
          bits, rises, load_t, done_t1, done_tl, busy_n, done_n, hi_n, dt_bad);
    check("div3_bits", bits[7:0], 8'h0F);
    check("div3_rises", rises, 8);
    check("div3_hi_n", hi_n, 24);
    check("div3_dt_stable", dt_bad, 0);
    check("div3_done_ofs", done_t1 - load_t, 49);
    check("div3_busy_n", busy_n, 50);
    check("div3_done_n", done_n, 1);
    repeat (4) tick();

    // start held high for 100 cycles: one frame only
    watch(0, 8'h3E, 100, -1, 8'h00, -1, 8'h00, 110,
          bits, rises, load_t, done_t1, done_tl, busy_n, done_n, hi_n, dt_bad);
    check("hold_done_n", done_n, 1);
    check("hold_busy_n", busy_n, 18);
    check("hold_bits", bits[7:0], 8'h3E);
    repeat (4) tick();

    // Two requests during frame 1: only the latest follows, with no bubble
    watch(0, 8'h81, 2, 5, 8'h3C, 10, 8'hC3, 45,
          bits, rises, load_t, done_t1, done_tl, busy_n, done_n, hi_n, dt_bad);
    check("b2b_bits", bits[15:0], 16'h81C3);
    check("b2b_rises", rises, 16);
    check("b2b_done_n", done_n, 2);
    check("b2b_done_gap", done_tl - done_t1, 18);
    check("b2b_busy_n", busy_n, 36);
    repeat (4) tick();

    // Reset at bit 4 of an all-ones frame
    drive(0, 1'b1, 8'hFF);
    repeat (3) tick();
    drive(0, 1'b0, 8'h00);
    repeat (8) tick();
    check("mid_busy", a_busy, 1);
    check("mid_segdt", a_dt, 1);
    rst = 1'b1;
    tick();
    check("mrst_busy", a_busy, 0);
    check("mrst_segdt", a_dt, 0);
    check("mrst_segclk", a_clk, 0);
    check("mrst_segclr", a_clr, 0);
    check("mrst_segen", a_en, 0);
    check("mrst_state", a_st, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mrel_segclr", a_clr, 1);
    check("mrel_segen", a_en, 1);
    done_n = 0;
    busy_n = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (a_done) done_n++;
      if (a_busy) busy_n++;
    end
    check("abandon_done_n", done_n, 0);
    check("abandon_busy_n", busy_n, 0);
    watch(0, 8'h5A, 2, -1, 8'h00, -1, 8'h00, 30,
          bits, rises, load_t, done_t1, done_tl, busy_n, done_n, hi_n, dt_bad);
    check("post_bits", bits[7:0], 8'h5A);
    check("post_done_ofs", done_t1 - load_t, 17);
    check("post_done_n", done_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
